// File: rtl/ai_tile_engine.sv
// Weight-stationary INT8 MAC tile: NUM_ROWS x NUM_COLS weight array, per-column accumulation of
// streamed input vectors, and a requantizing output stage with valid/ready backpressure.
module ai_tile_engine #(
   parameter int NUM_ROWS   = 4,
   parameter int NUM_COLS   = 4,
   parameter int DATA_WIDTH = 8,
   parameter int ACC_WIDTH  = 24,
   parameter int LEN_WIDTH  = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic [LEN_WIDTH-1:0]           cfg_len,
   input  logic [LEN_WIDTH-1:0]           cfg_passes,
   input  logic [4:0]                     cfg_shift,
   input  logic                           cfg_relu,
   output logic                           busy,
   output logic                           done,
   input  logic                           w_we,
   input  logic [$clog2(NUM_ROWS)-1:0]    w_row,
   input  logic [$clog2(NUM_COLS)-1:0]    w_col,
   input  logic [DATA_WIDTH-1:0]          w_data,
   output logic                           w_err,
   input  logic [NUM_ROWS*DATA_WIDTH-1:0] in_data,
   input  logic                           in_valid,
   output logic                           in_ready,
   output logic [NUM_COLS*DATA_WIDTH-1:0] out_data,
   output logic [NUM_COLS-1:0]            out_sat,
   output logic                           out_valid,
   input  logic                           out_ready
);

   localparam int DOT_W = 2*DATA_WIDTH + $clog2(NUM_ROWS + 1);
   // Requant intermediate is wide enough that acc plus a rounding term of up to 2^30 never overflows.
   localparam int QW    = ACC_WIDTH + 34;
   localparam logic [LEN_WIDTH-1:0] LEN_ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
   localparam logic signed [QW-1:0] Q_ONE = {{(QW-1){1'b0}}, 1'b1};
   localparam logic signed [QW-1:0] Q_MAX = (Q_ONE <<< (DATA_WIDTH-1)) - Q_ONE;
   localparam logic signed [QW-1:0] Q_MIN = -(Q_ONE <<< (DATA_WIDTH-1));

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ACCUM  = 3'd1,
      S_DRAIN  = 3'd2,
      S_QUANT  = 3'd3,
      S_OUTPUT = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   state_t                         state_q, state_d;
   logic [LEN_WIDTH-1:0]           len_q, len_d;
   logic [LEN_WIDTH-1:0]           passes_q, passes_d;
   logic [LEN_WIDTH-1:0]           beat_cnt_q, beat_cnt_d;
   logic [LEN_WIDTH-1:0]           pass_cnt_q, pass_cnt_d;
   logic [4:0]                     shift_q, shift_d;
   logic                           relu_q, relu_d;
   logic signed [DATA_WIDTH-1:0]   w_q [NUM_ROWS][NUM_COLS];
   logic signed [DATA_WIDTH-1:0]   w_d [NUM_ROWS][NUM_COLS];
   logic signed [DOT_W-1:0]        dot_q [NUM_COLS];
   logic signed [DOT_W-1:0]        dot_d [NUM_COLS];
   logic signed [DOT_W-1:0]        dot_sum_s [NUM_COLS];
   logic                           s1_valid_q, s1_valid_d;
   logic signed [ACC_WIDTH-1:0]    acc_q [NUM_COLS];
   logic signed [ACC_WIDTH-1:0]    acc_d [NUM_COLS];
   logic [NUM_COLS*DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic [NUM_COLS-1:0]            out_sat_q, out_sat_d;
   logic                           out_valid_q, out_valid_d;
   logic                           in_ready_q, in_ready_d;
   logic                           busy_q, busy_d;
   logic                           done_q, done_d;
   logic                           w_err_q, w_err_d;
   logic                           accept_s;

   // Round-half-up arithmetic shift, saturate to DATA_WIDTH, then optional ReLU; returns {sat, value}.
   function automatic logic [DATA_WIDTH:0] requant(
      input logic signed [ACC_WIDTH-1:0] acc,
      input logic [4:0]                  shift,
      input logic                        relu
   );
      logic signed [QW-1:0]  rnd_v;
      logic signed [QW-1:0]  t_v;
      logic [DATA_WIDTH-1:0] res_v;
      logic                  sat_v;
      if (shift == 5'd0) begin
         rnd_v = '0;
      end else begin
         rnd_v = Q_ONE <<< (shift - 5'd1);
      end
      t_v = (QW'(acc) + rnd_v) >>> shift;
      if (t_v > Q_MAX) begin
         res_v = Q_MAX[DATA_WIDTH-1:0];
         sat_v = 1'b1;
      end else if (t_v < Q_MIN) begin
         res_v = Q_MIN[DATA_WIDTH-1:0];
         sat_v = 1'b1;
      end else begin
         res_v = t_v[DATA_WIDTH-1:0];
         sat_v = 1'b0;
      end
      res_v = (relu && res_v[DATA_WIDTH-1]) ? {DATA_WIDTH{1'b0}} : res_v;
      return {sat_v, res_v};
   endfunction

   // Next-state, datapath and registered-output computation.
   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      passes_d   = passes_q;
      beat_cnt_d = beat_cnt_q;
      pass_cnt_d = pass_cnt_q;
      shift_d    = shift_q;
      relu_d     = relu_q;
      w_d        = w_q;
      out_data_d = out_data_q;
      out_sat_d  = out_sat_q;
      w_err_d    = 1'b0;
      accept_s   = in_valid && in_ready_q;

      if (w_we) begin
         if (state_q == S_IDLE) begin
            w_d[w_row][w_col] = w_data;
         end else begin
            w_err_d = 1'b1;
         end
      end else begin
         w_err_d = 1'b0;
      end

      s1_valid_d = accept_s;
      for (int c = 0; c < NUM_COLS; c++) begin
         dot_sum_s[c] = '0;
         for (int r = 0; r < NUM_ROWS; r++) begin
            dot_sum_s[c] = dot_sum_s[c]
               + DOT_W'(signed'(in_data[r*DATA_WIDTH +: DATA_WIDTH])) * DOT_W'(w_q[r][c]);
         end
         dot_d[c] = accept_s ? dot_sum_s[c] : dot_q[c];
         if (s1_valid_q) begin
            acc_d[c] = acc_q[c] + ACC_WIDTH'(dot_q[c]);
         end else begin
            acc_d[c] = acc_q[c];
         end
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d    = S_ACCUM;
               len_d      = cfg_len;
               passes_d   = (cfg_passes == {LEN_WIDTH{1'b0}}) ? LEN_ONE : cfg_passes;
               shift_d    = cfg_shift;
               relu_d     = cfg_relu;
               beat_cnt_d = '0;
               pass_cnt_d = '0;
               for (int c = 0; c < NUM_COLS; c++) begin
                  acc_d[c] = '0;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ACCUM: begin
            // Exit is decided one cycle after the last accept so that beat's product lands first.
            if (beat_cnt_q == len_q) begin
               state_d = S_DRAIN;
            end else if (accept_s) begin
               beat_cnt_d = beat_cnt_q + LEN_ONE;
            end else begin
               beat_cnt_d = beat_cnt_q;
            end
         end
         S_DRAIN: begin
            state_d = S_QUANT;
         end
         S_QUANT: begin
            for (int c = 0; c < NUM_COLS; c++) begin
               {out_sat_d[c], out_data_d[c*DATA_WIDTH +: DATA_WIDTH]} =
                  requant(acc_q[c], shift_q, relu_q);
            end
            state_d = S_OUTPUT;
         end
         S_OUTPUT: begin
            if (out_ready) begin
               if ((pass_cnt_q + LEN_ONE) < passes_q) begin
                  state_d    = S_ACCUM;
                  pass_cnt_d = pass_cnt_q + LEN_ONE;
                  beat_cnt_d = '0;
                  for (int c = 0; c < NUM_COLS; c++) begin
                     acc_d[c] = '0;
                  end
               end else begin
                  state_d = S_DONE;
               end
            end else begin
               state_d = S_OUTPUT;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      in_ready_d  = (state_d == S_ACCUM) && (beat_cnt_d < len_d);
      out_valid_d = (state_d == S_OUTPUT);
      busy_d      = (state_d != S_IDLE);
      done_d      = (state_d == S_DONE);
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         len_q       <= '0;
         passes_q    <= '0;
         beat_cnt_q  <= '0;
         pass_cnt_q  <= '0;
         shift_q     <= '0;
         relu_q      <= 1'b0;
         s1_valid_q  <= 1'b0;
         out_data_q  <= '0;
         out_sat_q   <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         w_err_q     <= 1'b0;
         for (int r = 0; r < NUM_ROWS; r++) begin
            for (int c = 0; c < NUM_COLS; c++) begin
               w_q[r][c] <= '0;
            end
         end
         for (int c = 0; c < NUM_COLS; c++) begin
            dot_q[c] <= '0;
            acc_q[c] <= '0;
         end
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         passes_q    <= passes_d;
         beat_cnt_q  <= beat_cnt_d;
         pass_cnt_q  <= pass_cnt_d;
         shift_q     <= shift_d;
         relu_q      <= relu_d;
         s1_valid_q  <= s1_valid_d;
         out_data_q  <= out_data_d;
         out_sat_q   <= out_sat_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         w_err_q     <= w_err_d;
         w_q         <= w_d;
         dot_q       <= dot_d;
         acc_q       <= acc_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign w_err     = w_err_q;
   assign in_ready  = in_ready_q;
   assign out_data  = out_data_q;
   assign out_sat   = out_sat_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_ai_tile_engine.sv
// Randomized and directed bench for ai_tile_engine against an integer-arithmetic reference model.
module tb_ai_tile_engine;

   localparam int NR = 4;
   localparam int NC = 4;

   logic        clk;
   logic        rst;
   logic        start;
   logic [7:0]  cfg_len;
   logic [7:0]  cfg_passes;
   logic [4:0]  cfg_shift;
   logic        cfg_relu;
   logic        busy;
   logic        done;
   logic        w_we;
   logic [1:0]  w_row;
   logic [1:0]  w_col;
   logic [7:0]  w_data;
   logic        w_err;
   logic [31:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] out_data;
   logic [3:0]  out_sat;
   logic        out_valid;
   logic        out_ready;

   int n_checks = 0;
   int n_fail   = 0;
   int done_cnt = 0;

   logic signed [7:0] vecs [0:255][0:NR-1];
   int                wm   [0:NR-1][0:NC-1];
   logic [31:0]       last_out;
   logic [3:0]        last_sat;

   ai_tile_engine dut (
      .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .cfg_passes(cfg_passes),
      .cfg_shift(cfg_shift), .cfg_relu(cfg_relu), .busy(busy), .done(done),
      .w_we(w_we), .w_row(w_row), .w_col(w_col), .w_data(w_data), .w_err(w_err),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_sat(out_sat), .out_valid(out_valid), .out_ready(out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count done pulses away from the active edge.
   always @(negedge clk) begin
      if (done) done_cnt <= done_cnt + 1;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] pack_vec(input int idx);
      logic [31:0] v;
      for (int r = 0; r < NR; r++) v[r*8 +: 8] = vecs[idx][r];
      return v;
   endfunction

   // Expected output of one pass: exact dot products, wrap mod 2^24, floor((acc + 2^(s-1)) / 2^s),
   // clip to int8, ReLU.
   function automatic void model_pass(input int p, input int len, input int sh, input bit relu,
                                      output logic [31:0] exp_d, output logic [3:0] exp_s);
      longint acc, d, v, t;
      exp_d = '0;
      exp_s = '0;
      for (int c = 0; c < NC; c++) begin
         acc = 0;
         for (int b = 0; b < len; b++)
            for (int r = 0; r < NR; r++)
               acc += longint'(vecs[p*len+b][r]) * longint'(wm[r][c]);
         acc = acc % 16777216;
         if (acc < 0) acc += 16777216;
         if (acc >= 8388608) acc -= 16777216;
         if (sh == 0) t = acc;
         else begin
            d = longint'(1) << sh;
            v = acc + d / 2;
            t = v / d;
            if ((v % d) != 0 && v < 0) t = t - 1;
         end
         if (t > 127) begin
            t = 127;
            exp_s[c] = 1'b1;
         end else if (t < -128) begin
            t = -128;
            exp_s[c] = 1'b1;
         end
         if (relu && t < 0) t = 0;
         exp_d[c*8 +: 8] = t[7:0];
      end
   endfunction

   task automatic write_w(input int r, input int c, input int v);
      logic [31:0] tmp;
      tmp    = v;
      w_we   = 1'b1;
      w_row  = tmp[1:0];
      w_row  = r[1:0];
      w_col  = c[1:0];
      w_data = tmp[7:0];
      @(posedge clk); #1;
      w_we = 1'b0;
      wm[r][c] = int'(signed'(tmp[7:0]));
      check_eq("w_err_idle_write", w_err, 0);
   endtask

   task automatic set_identity();
      for (int r = 0; r < NR; r++)
         for (int c = 0; c < NC; c++)
            write_w(r, c, (r == c) ? 1 : 0);
   endtask

   task automatic run_job(input int len, input int passes, input int sh, input bit relu,
                          input int stall, input bit poke_w);
      int np, b, n, dn0;
      bit accepted, stable;
      logic [31:0] exp_d, held_d, tmp;
      logic [3:0]  exp_s, held_s;
      np  = (passes == 0) ? 1 : passes;
      dn0 = done_cnt;
      tmp = len;        cfg_len    = tmp[7:0];
      tmp = passes;     cfg_passes = tmp[7:0];
      tmp = sh;         cfg_shift  = tmp[4:0];
      cfg_relu = relu;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check_eq("busy_after_start", busy, 1);
      if (poke_w) begin
         tmp    = $urandom;
         w_we   = 1'b1;
         w_row  = tmp[1:0];
         w_col  = tmp[3:2];
         w_data = tmp[15:8];
         @(posedge clk); #1;
         w_we = 1'b0;
         check_eq("w_err_busy_write", w_err, 1);
      end
      for (int p = 0; p < np; p++) begin
         model_pass(p, len, sh, relu, exp_d, exp_s);
         b = 0;
         n = 0;
         while (b < len && n < 200) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = pack_vec(p*len + b);
            accepted = in_valid && in_ready;
            @(posedge clk); #1;
            if (accepted) b++;
            n++;
         end
         in_valid = 1'b0;
         check_eq("beats_accepted", b, len);
         n = 0;
         while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
         end
         if (len > 0) check_eq("out_latency", n, 3);
         else check_eq("out_valid_seen", out_valid, 1);
         check_eq("in_ready_low_at_output", in_ready, 0);
         held_d = out_data;
         held_s = out_sat;
         stable = 1'b1;
         for (int k = 0; k < stall; k++) begin
            @(posedge clk); #1;
            if (!out_valid || out_data !== held_d || out_sat !== held_s || in_ready) stable = 1'b0;
         end
         if (stall > 0) check_eq("hold_under_backpressure", stable, 1);
         check_eq("out_data", out_data, exp_d);
         check_eq("out_sat", out_sat, exp_s);
         last_out  = out_data;
         last_sat  = out_sat;
         out_ready = 1'b1;
         @(posedge clk); #1;
         out_ready = 1'b0;
         check_eq("out_valid_after_handshake", out_valid, 0);
         if (p < np - 1) check_eq("no_done_between_passes", done, 0);
      end
      check_eq("done_pulse", done, 1);
      @(posedge clk); #1;
      check_eq("done_single_pulse", done_cnt - dn0, 1);
      check_eq("idle_after_done", busy, 0);
   endtask

   initial begin
      logic [31:0] rnd;
      int dn0, len, passes;
      rst = 1'b1; start = 1'b0; cfg_len = '0; cfg_passes = '0; cfg_shift = '0; cfg_relu = 1'b0;
      w_we = 1'b0; w_row = '0; w_col = '0; w_data = '0;
      in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
      for (int r = 0; r < NR; r++) for (int c = 0; c < NC; c++) wm[r][c] = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check_eq("reset_busy", busy, 0);
      check_eq("reset_done", done, 0);
      check_eq("reset_in_ready", in_ready, 0);
      check_eq("reset_out_valid", out_valid, 0);
      check_eq("reset_out_data", out_data, 0);
      check_eq("reset_w_err", w_err, 0);

      // Identity weights, three [1,2,3,4] beats, no shift.
      set_identity();
      for (int i = 0; i < 3; i++) for (int r = 0; r < NR; r++) vecs[i][r] = 8'(r + 1);
      run_job(3, 1, 0, 1'b0, 0, 1'b0);
      check_eq("identity_sum", last_out, 32'h0C090603);
      check_eq("identity_sat", last_sat, 4'h0);

      // Saturation with all-127 operands, then negative saturation hidden by ReLU.
      for (int r = 0; r < NR; r++) for (int c = 0; c < NC; c++) write_w(r, c, 127);
      for (int r = 0; r < NR; r++) vecs[0][r] = 8'sd127;
      run_job(1, 1, 0, 1'b0, 0, 1'b0);
      check_eq("sat_pos_data", last_out, 32'h7F7F7F7F);
      check_eq("sat_pos_flags", last_sat, 4'hF);
      for (int r = 0; r < NR; r++) for (int c = 0; c < NC; c++) write_w(r, c, 255);
      run_job(1, 1, 0, 1'b1, 0, 1'b0);
      check_eq("relu_neg_data", last_out, 32'h00000000);

      // Round-half-up on positive and negative accumulators.
      set_identity();
      vecs[0][0] = 8'sd5; vecs[0][1] = -8'sd5; vecs[0][2] = 8'sd0; vecs[0][3] = 8'sd0;
      run_job(1, 1, 1, 1'b0, 0, 1'b0);
      check_eq("round_shift1", last_out, 32'h0000FE03);
      vecs[0][0] = -8'sd6; vecs[0][1] = 8'sd0; vecs[0][2] = 8'sd0; vecs[0][3] = 8'sd0;
      run_job(1, 1, 2, 1'b0, 0, 1'b0);
      check_eq("round_shift2_neg", last_out, 32'h000000FF);

      // Two passes with a 10-cycle output stall; random weights and data.
      for (int r = 0; r < NR; r++) for (int c = 0; c < NC; c++) write_w(r, c, $urandom_range(0, 255));
      for (int i = 0; i < 8; i++) for (int r = 0; r < NR; r++) begin
         rnd = $urandom; vecs[i][r] = rnd[7:0];
      end
      run_job(2, 2, 3, 1'b0, 10, 1'b0);

      // Empty job and a write attempt while busy; then passes=0 behaves as one pass.
      run_job(0, 1, 4, 1'b0, 0, 1'b1);
      check_eq("len0_data", last_out, 32'h00000000);
      run_job(2, 1, 0, 1'b0, 0, 1'b1);
      run_job(2, 0, 1, 1'b1, 2, 1'b0);

      // Reset in the middle of accumulation aborts the job and clears weights.
      set_identity();
      cfg_len = 8'd5; cfg_passes = 8'd1; cfg_shift = 5'd0; cfg_relu = 1'b0;
      dn0 = done_cnt;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      in_valid = 1'b1;
      in_data  = 32'h04030201;
      repeat (2) @(posedge clk);
      #1 in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check_eq("abort_busy", busy, 0);
      check_eq("abort_in_ready", in_ready, 0);
      check_eq("abort_out_valid", out_valid, 0);
      for (int r = 0; r < NR; r++) for (int c = 0; c < NC; c++) wm[r][c] = 0;
      repeat (8) @(posedge clk);
      #1 check_eq("abort_no_done", done_cnt - dn0, 0);
      for (int i = 0; i < 3; i++) for (int r = 0; r < NR; r++) vecs[i][r] = 8'sd9;
      run_job(3, 1, 0, 1'b0, 0, 1'b0);
      check_eq("weights_cleared_by_reset", last_out, 32'h00000000);

      // Randomized jobs.
      for (int j = 0; j < 8; j++) begin
         for (int r = 0; r < NR; r++) for (int c = 0; c < NC; c++)
            write_w(r, c, $urandom_range(0, 255));
         len    = $urandom_range(1, 6);
         passes = $urandom_range(1, 3);
         for (int i = 0; i < len * passes; i++) for (int r = 0; r < NR; r++) begin
            rnd = $urandom; vecs[i][r] = rnd[7:0];
         end
         rnd = $urandom;
         run_job(len, passes, $urandom_range(0, 14), rnd[0], $urandom_range(0, 4), rnd[1]);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
